// File: rtl/pinmux_pkg.sv
// pinmux_pkg: shared register map, field geometry, per-pin FSM state type and
// the registered SEL-write payload used between the bus decode and the pins.
package pinmux_pkg;

    localparam int unsigned ADR_W         = 6;
    localparam int unsigned DAT_W         = 32;
    localparam int unsigned BE_W          = 4;
    localparam int unsigned FIELD_W       = 4;
    localparam int unsigned PINS_PER_WORD = 8;
    localparam int unsigned SEL_WORDS     = 4;
    localparam int unsigned CNT_W         = 4;

    localparam logic [ADR_W-1:0] SEL_BASE   = 6'h00;
    localparam logic [ADR_W-1:0] STATUS_OFS = 6'h10;
    localparam logic [ADR_W-1:0] LOCK_OFS   = 6'h14;

    typedef enum logic {
        ACTIVE = 1'b0,
        GUARD  = 1'b1
    } pin_state_e;

    // Accepted SEL write, applied to the pins one cycle after its ack.
    typedef struct packed {
        logic [1:0]       word;
        logic [BE_W-1:0]  be;
        logic [DAT_W-1:0] dat;
    } sel_wr_t;

endpackage

// File: rtl/pinmux_if.sv
// pinmux_if: Wishbone slave bus of the pin mux register block.
//   master: drives wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i[5:0], wb_dat_i[31:0], wb_sel_i[3:0]
//   slave : drives wb_dat_o[31:0], wb_ack_o, wb_err_o
interface pinmux_if;
    import pinmux_pkg::*;

    logic             wb_cyc_i;
    logic             wb_stb_i;
    logic             wb_we_i;
    logic [ADR_W-1:0] wb_adr_i;
    logic [DAT_W-1:0] wb_dat_i;
    logic [BE_W-1:0]  wb_sel_i;
    logic [DAT_W-1:0] wb_dat_o;
    logic             wb_ack_o;
    logic             wb_err_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );

endinterface

// File: rtl/pinmux_pin.sv
// pinmux_pin: one pad's function select FSM with tristate guard interval,
// pad-input synchroniser and output/input function muxing.
//   clk, rst_n     : clock, async active-low reset
//   i_we, i_wsel   : SEL field write strobe and value
//   i_fn_o/i_fn_en : per-function output and output enable
//   o_fn_i_c       : synchronised pad input, only to the active function (others 1)
//   o_pad_c/o_pad_en_c : pad drive and enable (combinational)
//   i_pad          : raw pad input
//   o_busy_c       : pin is in its guard interval
//   o_tgt_sel      : programmed select value for readback
module pinmux_pin
    import pinmux_pkg::*;
#(
    parameter int unsigned NO_OF_FUNCS  = 4,
    parameter int unsigned GUARD_CYCLES = 2,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_we,
    input  logic [FIELD_W-1:0]     i_wsel,
    input  logic [NO_OF_FUNCS-1:0] i_fn_o,
    input  logic [NO_OF_FUNCS-1:0] i_fn_en,
    output logic [NO_OF_FUNCS-1:0] o_fn_i_c,
    output logic                   o_pad_c,
    output logic                   o_pad_en_c,
    input  logic                   i_pad,
    output logic                   o_busy_c,
    output logic [FIELD_W-1:0]     o_tgt_sel
);

    localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_CYCLES - 1);

    pin_state_e         r_state, w_state_nxt;
    logic [FIELD_W-1:0] r_cur_sel, w_cur_sel_nxt;
    logic [FIELD_W-1:0] r_tgt_sel, w_tgt_sel_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [SYNC_STAGES-1:0] r_sync;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ACTIVE;
            r_cur_sel <= '0;
            r_tgt_sel <= '0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cur_sel <= w_cur_sel_nxt;
            r_tgt_sel <= w_tgt_sel_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    // Pad input synchroniser; idles high so inputs look released out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pad};
        end
    end

    // Next state and pad/function muxing.
    always_comb begin
        w_state_nxt   = r_state;
        w_cur_sel_nxt = r_cur_sel;
        w_tgt_sel_nxt = r_tgt_sel;
        w_cnt_nxt     = r_cnt;
        o_pad_c       = 1'b0;
        o_pad_en_c    = 1'b0;
        o_busy_c      = 1'b0;
        o_fn_i_c      = '1;

        case (r_state)
            ACTIVE: begin
                for (int f = 0; f < NO_OF_FUNCS; f++) begin
                    if (r_cur_sel == FIELD_W'(f)) begin
                        o_pad_c     = i_fn_o[f];
                        o_pad_en_c  = i_fn_en[f];
                        o_fn_i_c[f] = r_sync[SYNC_STAGES-1];
                    end
                end
                if (i_we && (i_wsel != r_cur_sel)) begin
                    w_tgt_sel_nxt = i_wsel;
                    w_cnt_nxt     = GUARD_LOAD;
                    w_state_nxt   = GUARD;
                end
            end
            GUARD: begin
                o_busy_c = 1'b1;
                // A fresh target restarts the guard, even on its last cycle.
                if (i_we && (i_wsel != r_tgt_sel)) begin
                    w_tgt_sel_nxt = i_wsel;
                    w_cnt_nxt     = GUARD_LOAD;
                end else if (r_cnt == '0) begin
                    w_cur_sel_nxt = r_tgt_sel;
                    w_state_nxt   = ACTIVE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ACTIVE;
            end
        endcase
    end

    assign o_tgt_sel = r_tgt_sel;

endmodule

// File: rtl/pinmux_ctrl.sv
// pinmux_ctrl: routes NO_OF_PINS pads to one of NO_OF_FUNCS peripheral functions
// (function 0 = GPIO) under Wishbone-programmed SEL registers, with a tristate
// guard on every function change.
//   wb_clk_i, wb_rst_ni : clock, async active-low reset
//   wb                  : Wishbone slave (pinmux_if.slave)
//   fn_o_i/fn_en_i      : peripheral outputs/enables, bit [p*NO_OF_FUNCS+f]
//   fn_i_o              : synchronised pad inputs back to the functions
//   pad_o/pad_en_o/pad_i: pad ring connections
//   busy_o              : per-pin guard interval indicator
// Build option: define PINMUX_LOCK_EN to add the write-1-to-set LOCK register.
module pinmux_ctrl
    import pinmux_pkg::*;
#(
    parameter int unsigned NO_OF_PINS   = 24,
    parameter int unsigned NO_OF_FUNCS  = 4,
    parameter int unsigned GUARD_CYCLES = 2,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic                              wb_clk_i,
    input  logic                              wb_rst_ni,
    pinmux_if.slave                           wb,
    input  logic [NO_OF_PINS*NO_OF_FUNCS-1:0] fn_o_i,
    input  logic [NO_OF_PINS*NO_OF_FUNCS-1:0] fn_en_i,
    output logic [NO_OF_PINS*NO_OF_FUNCS-1:0] fn_i_o,
    output logic [NO_OF_PINS-1:0]             pad_o,
    output logic [NO_OF_PINS-1:0]             pad_en_o,
    input  logic [NO_OF_PINS-1:0]             pad_i,
    output logic [NO_OF_PINS-1:0]             busy_o
);

    logic                 r_ack, r_err, r_done, r_wr_stb;
    logic [DAT_W-1:0]     r_dat;
    sel_wr_t              r_wr;

    logic                 w_req, w_err, w_fld_bad, w_is_sel, w_is_status, w_sel_wr;
    logic [DAT_W-1:0]     w_rdata;
    logic [SEL_WORDS*DAT_W-1:0] w_sel_flat;
    logic [FIELD_W-1:0]   w_tgt_sel [NO_OF_PINS];
    logic [NO_OF_PINS-1:0] w_pin_we;

`ifdef PINMUX_LOCK_EN
    logic [NO_OF_PINS-1:0] r_lock;
    logic [NO_OF_PINS-1:0] w_cover;
    logic [DAT_W-1:0]      w_be_mask;
    logic                  w_is_lock, w_lock_hit;
`endif

    // One response per cyc&stb assertion; r_done blocks a repeat until it drops.
    assign w_req = wb.wb_cyc_i && wb.wb_stb_i && !r_done;

    assign w_is_sel    = (wb.wb_adr_i[5:4] == 2'b00) && (wb.wb_adr_i[1:0] == 2'b00);
    assign w_is_status = (wb.wb_adr_i == STATUS_OFS);

    // Any enabled field carrying a function number that does not exist.
    always_comb begin
        w_fld_bad = 1'b0;
        for (int j = 0; j < PINS_PER_WORD; j++) begin
            if (wb.wb_sel_i[j/2] && (32'(wb.wb_dat_i[FIELD_W*j +: FIELD_W]) >= NO_OF_FUNCS)) begin
                w_fld_bad = 1'b1;
            end
        end
    end

    // Programmed selects packed as the SEL register image; absent pins read 0.
    always_comb begin
        w_sel_flat = '0;
        for (int p = 0; p < NO_OF_PINS; p++) begin
            w_sel_flat[FIELD_W*p +: FIELD_W] = w_tgt_sel[p];
        end
    end

`ifdef PINMUX_LOCK_EN
    assign w_is_lock = (wb.wb_adr_i == LOCK_OFS);
    assign w_be_mask = {{8{wb.wb_sel_i[3]}}, {8{wb.wb_sel_i[2]}},
                        {8{wb.wb_sel_i[1]}}, {8{wb.wb_sel_i[0]}}};

    // Pins whose SEL field lies in an enabled byte lane of the addressed word.
    always_comb begin
        w_cover = '0;
        for (int p = 0; p < NO_OF_PINS; p++) begin
            w_cover[p] = wb.wb_sel_i[(p % PINS_PER_WORD) / 2] &&
                         (wb.wb_adr_i[3:2] == 2'(p / PINS_PER_WORD));
        end
    end

    assign w_lock_hit = |(w_cover & r_lock);
`endif

    // Address decode, read mux and error classification.
    always_comb begin
        w_rdata = '0;
        w_err   = 1'b0;
        if (w_is_sel) begin
            w_rdata = w_sel_flat[{wb.wb_adr_i[3:2], 5'd0} +: DAT_W];
`ifdef PINMUX_LOCK_EN
            w_err   = wb.wb_we_i && (w_fld_bad || w_lock_hit);
`else
            w_err   = wb.wb_we_i && w_fld_bad;
`endif
        end else if (w_is_status) begin
            w_rdata = DAT_W'(busy_o);
            w_err   = wb.wb_we_i;
`ifdef PINMUX_LOCK_EN
        end else if (w_is_lock) begin
            w_rdata = DAT_W'(r_lock);
`endif
        end else begin
            w_err = 1'b1;
        end
    end

    assign w_sel_wr = w_req && wb.wb_we_i && w_is_sel && !w_err;

    // Bus response and registered SEL write payload.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
            r_dat    <= '0;
            r_done   <= 1'b0;
            r_wr_stb <= 1'b0;
            r_wr     <= '0;
        end else begin
            r_wr_stb <= w_sel_wr;
            if (w_sel_wr) begin
                r_wr <= '{word: wb.wb_adr_i[3:2], be: wb.wb_sel_i, dat: wb.wb_dat_i};
            end
            if (w_req) begin
                r_ack  <= !w_err;
                r_err  <= w_err;
                r_dat  <= w_err ? '0 : w_rdata;
                r_done <= 1'b1;
            end else begin
                r_ack <= 1'b0;
                r_err <= 1'b0;
                r_dat <= '0;
                if (!(wb.wb_cyc_i && wb.wb_stb_i)) begin
                    r_done <= 1'b0;
                end
            end
        end
    end

`ifdef PINMUX_LOCK_EN
    // Sticky lock bits, cleared only by reset.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_lock <= '0;
        end else if (w_req && wb.wb_we_i && w_is_lock) begin
            r_lock <= r_lock | NO_OF_PINS'(wb.wb_dat_i & w_be_mask);
        end
    end
`endif

    assign wb.wb_ack_o = r_ack;
    assign wb.wb_err_o = r_err;
    assign wb.wb_dat_o = r_dat;

    // Per-pin select FSMs.
    for (genvar p = 0; p < NO_OF_PINS; p++) begin : g_pin
        localparam int unsigned WORD = p / PINS_PER_WORD;
        localparam int unsigned SLOT = p % PINS_PER_WORD;

        assign w_pin_we[p] = r_wr_stb && (r_wr.word == 2'(WORD)) && r_wr.be[SLOT/2];

        pinmux_pin #(
            .NO_OF_FUNCS  (NO_OF_FUNCS),
            .GUARD_CYCLES (GUARD_CYCLES),
            .SYNC_STAGES  (SYNC_STAGES)
        ) u_pin (
            .clk        (wb_clk_i),
            .rst_n      (wb_rst_ni),
            .i_we       (w_pin_we[p]),
            .i_wsel     (r_wr.dat[FIELD_W*SLOT +: FIELD_W]),
            .i_fn_o     (fn_o_i[p*NO_OF_FUNCS +: NO_OF_FUNCS]),
            .i_fn_en    (fn_en_i[p*NO_OF_FUNCS +: NO_OF_FUNCS]),
            .o_fn_i_c   (fn_i_o[p*NO_OF_FUNCS +: NO_OF_FUNCS]),
            .o_pad_c    (pad_o[p]),
            .o_pad_en_c (pad_en_o[p]),
            .i_pad      (pad_i[p]),
            .o_busy_c   (busy_o[p]),
            .o_tgt_sel  (w_tgt_sel[p])
        );
    end

endmodule
